// File: rtl/trace_pkg.sv
// Shared types for the retire trace buffer: record kinds, record layout and field widths.
package trace_pkg;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  typedef enum logic [1:0] {
    KIND_REG  = 2'd0,
    KIND_MEM  = 2'd1,
    KIND_PC   = 2'd2,
    KIND_RSVD = 2'd3
  } kind_e;

  typedef struct packed {
    kind_e          kind;
    logic [DW-1:0]  pc;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  data;
  } trace_rec_t;

  localparam int unsigned REC_W = $bits(trace_rec_t);

endpackage

// File: rtl/retire_trace_buffer_if.sv
// Retire-lane capture bus plus valid/ready drain port of the trace buffer.
interface retire_trace_buffer_if
  import trace_pkg::*;
#(
  parameter int unsigned LANES = 2
);

  logic [LANES-1:0]    ret_valid;
  logic [2*LANES-1:0]  ret_kind;
  logic [DW*LANES-1:0] ret_pc;
  logic [AW*LANES-1:0] ret_addr;
  logic [DW*LANES-1:0] ret_data;
  logic                out_valid;
  logic                out_ready;
  trace_rec_t          out_rec;

  modport master (
    output ret_valid, ret_kind, ret_pc, ret_addr, ret_data, out_ready,
    input  out_valid, out_rec
  );

  modport slave (
    input  ret_valid, ret_kind, ret_pc, ret_addr, ret_data, out_ready,
    output out_valid, out_rec
  );

endinterface

// File: rtl/retire_lane_compact.sv
// Per-lane accept decision and ascending-order slot offsets for packing accepted lanes.
module retire_lane_compact
  import trace_pkg::*;
#(
  parameter int unsigned  LANES = 2,
  localparam int unsigned SW    = $clog2(LANES + 1)
) (
  input  logic [LANES-1:0]    valid,
  input  logic [2*LANES-1:0]  kind,
  input  logic [3:0]          kind_mask,
  input  logic                enable,
  input  logic                stopped,
  output logic [LANES-1:0]    accept_c,
  output logic [LANES*SW-1:0] slot_c,
  output logic [SW-1:0]       n_acc_c
);

  logic [SW-1:0] run;
  logic [1:0]    k;
  logic          acc;

  // Running prefix sum: each accepted lane gets the count of accepted lanes below it.
  always_comb begin
    run      = '0;
    k        = '0;
    acc      = 1'b0;
    accept_c = '0;
    slot_c   = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      k   = kind[2*i +: 2];
      acc = valid[i] & enable & ~stopped & (k != KIND_RSVD) & kind_mask[k];
      accept_c[i]       = acc;
      slot_c[i*SW +: SW] = run;
      run = run + SW'(acc);
    end
    n_acc_c = run;
  end

endmodule

// File: rtl/retire_trace_buffer.sv
// Circular retire-trace buffer with kind filter, stop/wrap on full, halt freeze and drop accounting.
module retire_trace_buffer
  import trace_pkg::*;
#(
  parameter int unsigned LANES = 2,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNTW  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  retire_trace_buffer_if.slave         bus,
  input  logic [3:0]                   kind_mask,
  input  logic                         enable,
  input  logic                         wrap_mode,
  input  logic                         halt,
  input  logic                         restart,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [CNTW-1:0]              drop_cnt,
  output logic                         overflow,
  output logic                         stopped
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = $clog2(LANES + 1);

  trace_rec_t          mem [DEPTH];
  trace_rec_t          lane_rec [LANES];
  logic [PW-1:0]       rp;
  logic [PW-1:0]       wp;
  logic [LANES-1:0]    accept;
  logic [LANES*SW-1:0] slot;
  logic [SW-1:0]       n_acc;
  logic [SW-1:0]       n_wr;
  logic [SW-1:0]       excess;
  logic [SW-1:0]       dropped;
  logic [CW:0]         free;
  logic [CNTW:0]       drop_sum;
  logic                pop;

  retire_lane_compact #(.LANES(LANES)) u_compact (
    .valid     (bus.ret_valid),
    .kind      (bus.ret_kind),
    .kind_mask (kind_mask),
    .enable    (enable),
    .stopped   (stopped),
    .accept_c  (accept),
    .slot_c    (slot),
    .n_acc_c   (n_acc)
  );

  assign bus.out_valid = (count != '0);
  assign bus.out_rec   = mem[rp];

  // Split accepted lanes into written / overwritten-oldest / dropped-newest.
  always_comb begin
    pop      = (count != '0) & bus.out_ready;
    free     = (CW+1)'(DEPTH) - (CW+1)'(count) + (CW+1)'(pop);
    n_wr     = n_acc;
    excess   = '0;
    dropped  = '0;
    if ((CW+1)'(n_acc) > free) begin
      if (wrap_mode) begin
        excess  = n_acc - SW'(free);
        dropped = excess;
      end else begin
        n_wr    = SW'(free);
        dropped = n_acc - SW'(free);
      end
    end
    drop_sum = (CNTW+1)'(drop_cnt) + (CNTW+1)'(dropped);
    for (int i = 0; i < int'(LANES); i++) begin
      lane_rec[i].kind = kind_e'(bus.ret_kind[2*i +: 2]);
      lane_rec[i].pc   = bus.ret_pc[DW*i +: DW];
      lane_rec[i].addr = bus.ret_addr[AW*i +: AW];
      lane_rec[i].data = bus.ret_data[DW*i +: DW];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rp       <= '0;
      wp       <= '0;
      count    <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
      stopped  <= 1'b0;
    end else begin
      wp       <= wp + PW'(n_wr);
      rp       <= rp + PW'(pop) + PW'(excess);
      count    <= count + CW'(n_wr) - CW'(pop) - CW'(excess);
      drop_cnt <= drop_sum[CNTW] ? '1 : drop_sum[CNTW-1:0];
      overflow <= overflow | (dropped != '0);
      if (halt) begin
        stopped <= 1'b1;
      end else if (restart) begin
        stopped <= 1'b0;
      end
    end
  end

  // Storage is not reset; only lanes that fit this cycle are written.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (accept[i] && (slot[i*SW +: SW] < n_wr)) begin
          mem[wp + PW'(slot[i*SW +: SW])] <= lane_rec[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Randomized bench for retire_trace_buffer checked every cycle against a queue-based model.
module tb_retire_trace_buffer;
  import trace_pkg::*;

  localparam int unsigned LANES = 2;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNTW  = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      kind_mask;
  logic            enable;
  logic            wrap_mode;
  logic            halt;
  logic            restart;
  logic [CW-1:0]   count;
  logic [CNTW-1:0] drop_cnt;
  logic            overflow;
  logic            stopped;

  retire_trace_buffer_if #(.LANES(LANES)) bus ();

  retire_trace_buffer #(.LANES(LANES), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .kind_mask (kind_mask),
    .enable    (enable),
    .wrap_mode (wrap_mode),
    .halt      (halt),
    .restart   (restart),
    .count     (count),
    .drop_cnt  (drop_cnt),
    .overflow  (overflow),
    .stopped   (stopped)
  );

  always #5 clk = ~clk;

  trace_rec_t q[$];
  int         m_drop;
  bit         m_ovf;
  bit         m_stp;
  int         checks   = 0;
  int         failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: FIFO queue of records; full handling by dropping newest or evicting oldest.
  task automatic model_step();
    bit         pop;
    int         lost;
    logic [1:0] k;
    trace_rec_t r;
    trace_rec_t acc[$];
    pop  = (q.size() != 0) && bus.out_ready;
    lost = 0;
    if (reset) begin
      q.delete();
      m_drop = 0;
      m_ovf  = 0;
      m_stp  = 0;
      return;
    end
    for (int i = 0; i < int'(LANES); i++) begin
      k = bus.ret_kind[2*i +: 2];
      if (bus.ret_valid[i] && enable && !m_stp && k != 2'd3 && kind_mask[k]) begin
        r.kind = kind_e'(k);
        r.pc   = bus.ret_pc[DW*i +: DW];
        r.addr = bus.ret_addr[AW*i +: AW];
        r.data = bus.ret_data[DW*i +: DW];
        acc.push_back(r);
      end
    end
    if (pop) void'(q.pop_front());
    foreach (acc[j]) begin
      if (wrap_mode) begin
        q.push_back(acc[j]);
        if (q.size() > int'(DEPTH)) begin
          void'(q.pop_front());
          lost++;
        end
      end else if (q.size() < int'(DEPTH)) begin
        q.push_back(acc[j]);
      end else begin
        lost++;
      end
    end
    m_drop = m_drop + lost;
    if (m_drop > (1 << CNTW) - 1) m_drop = (1 << CNTW) - 1;
    if (lost > 0) m_ovf = 1;
    if (halt) m_stp = 1;
    else if (restart) m_stp = 0;
  endtask

  task automatic check_all();
    chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
    if (q.size() != 0) chk("out_rec", 64'(bus.out_rec), 64'(q[0]));
    chk("count", 64'(count), 64'(q.size()));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("stopped", 64'(stopped), 64'(m_stp));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_lane(input int i, input bit v, input logic [1:0] k,
                          input logic [15:0] pc, input logic [15:0] a, input logic [15:0] d);
    bus.ret_valid[i]        = v;
    bus.ret_kind[2*i +: 2]  = k;
    bus.ret_pc[DW*i +: DW]  = pc;
    bus.ret_addr[AW*i +: AW] = a;
    bus.ret_data[DW*i +: DW] = d;
  endtask

  task automatic fill5();
    for (int j = 0; j < 5; j++) begin
      set_lane(0, 1'b1, KIND_REG, 16'h0100 + 16'(2*j), 16'(j), 16'hA000 + 16'(j));
      set_lane(1, 1'b1, KIND_MEM, 16'h0101 + 16'(2*j), 16'h0040 + 16'(j), 16'hB000 + 16'(j));
      tick();
    end
    bus.ret_valid = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  trace_rec_t exp_rec;

  initial begin
    reset         = 1'b1;
    kind_mask     = 4'b0111;
    enable        = 1'b1;
    wrap_mode     = 1'b0;
    halt          = 1'b0;
    restart       = 1'b0;
    bus.ret_valid = '0;
    bus.ret_kind  = '0;
    bus.ret_pc    = '0;
    bus.ret_addr  = '0;
    bus.ret_data  = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_valid", 64'(bus.out_valid), 64'd0);
    reset = 1'b0;

    // Two lanes in one cycle, drained in lane order.
    bus.out_ready = 1'b1;
    set_lane(0, 1'b1, KIND_REG, 16'h0010, 16'h0003, 16'h1234);
    set_lane(1, 1'b1, KIND_MEM, 16'h0011, 16'h0040, 16'hBEEF);
    tick();
    bus.ret_valid = '0;
    exp_rec = '{kind: KIND_REG, pc: 16'h0010, addr: 16'h0003, data: 16'h1234};
    chk("tp1_cnt2", 64'(count), 64'd2);
    chk("tp1_rec0", 64'(bus.out_rec), 64'(exp_rec));
    tick();
    exp_rec = '{kind: KIND_MEM, pc: 16'h0011, addr: 16'h0040, data: 16'hBEEF};
    chk("tp1_cnt1", 64'(count), 64'd1);
    chk("tp1_rec1", 64'(bus.out_rec), 64'(exp_rec));
    tick();
    chk("tp1_cnt0", 64'(count), 64'd0);

    // Stop-on-full: 10 offered, 8 kept, then pop+2 on a full buffer.
    bus.out_ready = 1'b0;
    fill5();
    chk("tp2_cnt", 64'(count), 64'd8);
    chk("tp2_drop", 64'(drop_cnt), 64'd2);
    chk("tp2_ovf", 64'(overflow), 64'd1);
    chk("tp2_head", 64'(bus.out_rec.pc), 64'h0100);
    bus.out_ready = 1'b1;
    set_lane(0, 1'b1, KIND_REG, 16'h0200, 16'h0001, 16'h0001);
    set_lane(1, 1'b1, KIND_REG, 16'h0201, 16'h0002, 16'h0002);
    tick();
    bus.ret_valid = '0;
    chk("tp4_cnt", 64'(count), 64'd8);
    chk("tp4_drop", 64'(drop_cnt), 64'd3);
    chk("tp4_head", 64'(bus.out_rec.pc), 64'h0101);
    repeat (10) tick();
    chk("tp4_empty", 64'(count), 64'd0);
    do_reset();

    // Wrap mode: oldest two overwritten.
    wrap_mode     = 1'b1;
    bus.out_ready = 1'b0;
    fill5();
    chk("tp3_cnt", 64'(count), 64'd8);
    chk("tp3_drop", 64'(drop_cnt), 64'd2);
    chk("tp3_head", 64'(bus.out_rec.pc), 64'h0102);
    do_reset();

    // Kind filter.
    wrap_mode = 1'b0;
    kind_mask = 4'b0100;
    set_lane(0, 1'b1, KIND_REG, 16'h0020, 16'h0005, 16'h5555);
    set_lane(1, 1'b1, KIND_PC, 16'h0030, 16'h0000, 16'h0200);
    tick();
    bus.ret_valid = '0;
    chk("tp5_cnt", 64'(count), 64'd1);
    chk("tp5_drop", 64'(drop_cnt), 64'd0);
    chk("tp5_kind", 64'(bus.out_rec.kind), 64'(KIND_PC));
    chk("tp5_tgt", 64'(bus.out_rec.data), 64'h0200);

    // Halt freeze, restart, halt-beats-restart, reset mid-fill.
    kind_mask = 4'b0111;
    set_lane(0, 1'b1, KIND_PC, 16'h0040, 16'h0000, 16'h0300);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("tp6_cnt", 64'(count), 64'd2);
    chk("tp6_stop", 64'(stopped), 64'd1);
    set_lane(1, 1'b1, KIND_MEM, 16'h0041, 16'h0044, 16'h0444);
    tick();
    chk("tp6_frozen", 64'(count), 64'd2);
    bus.ret_valid = '0;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("tp6_restart", 64'(stopped), 64'd0);
    set_lane(0, 1'b1, KIND_REG, 16'h0050, 16'h0007, 16'h0777);
    tick();
    chk("tp6_resume", 64'(count), 64'd3);
    bus.ret_valid = '0;
    halt = 1'b1;
    tick();
    restart = 1'b1;
    tick();
    chk("tp6_haltwins", 64'(stopped), 64'd1);
    halt    = 1'b0;
    restart = 1'b0;
    set_lane(0, 1'b1, KIND_REG, 16'h0060, 16'h0001, 16'h0001);
    set_lane(1, 1'b1, KIND_REG, 16'h0061, 16'h0002, 16'h0002);
    do_reset();
    chk("tp6_rst_cnt", 64'(count), 64'd0);
    chk("tp6_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("tp6_rst_drop", 64'(drop_cnt), 64'd0);

    // Randomized traffic with phases of slow and fast draining.
    for (int n = 0; n < 4000; n++) begin
      bus.ret_valid = LANES'($urandom);
      bus.ret_kind  = (2*LANES)'($urandom);
      bus.ret_pc    = (DW*LANES)'($urandom);
      bus.ret_addr  = (AW*LANES)'($urandom);
      bus.ret_data  = (DW*LANES)'($urandom);
      kind_mask     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111;
      enable        = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 49) == 0) wrap_mode = ~wrap_mode;
      bus.out_ready = ((n / 300) % 2 == 0) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
      halt          = ($urandom_range(0, 99) == 0);
      restart       = ($urandom_range(0, 19) == 0);
      reset         = ($urandom_range(0, 599) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/retire_trace_buffer.md
Name: retire_trace_buffer

Overview:
Synthesizable successor to the simulation-only retirement logger. It captures up to LANES retire records per cycle (register write, memory store or jump) from the execute/retire stage into a circular trace buffer. A valid/ready drain port empties the buffer toward a debug or trace sink. It adds a kind filter, stop-on-full and wrap (overwrite-oldest) modes, halt-triggered freeze, and drop accounting.

Parameters:
LANES, 2, retire lanes sampled per cycle (1..4)
DEPTH, 16, buffer entries; power of two, DEPTH >= 2*LANES
AW, 16, address field width (register index or memory address)
DW, 16, data / pc field width
CNTW, 16, drop counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ret_valid  in  LANES  per-lane retire strobe
ret_kind  in  2*LANES  per-lane kind: 0 REG, 1 MEM, 2 PC, 3 reserved
ret_pc  in  DW*LANES  per-lane pc of the retiring instruction
ret_addr  in  AW*LANES  per-lane reg index / mem addr (don't-care for PC)
ret_data  in  DW*LANES  per-lane written data, or jump target for PC
kind_mask  in  4  bit k enables capture of kind k
enable  in  1  capture enable
wrap_mode  in  1  0 = stop-on-full (drop newest), 1 = overwrite oldest
halt  in  1  CPU halt; freezes capture
restart  in  1  pulse; clears stopped
out_valid  out  1  head entry available
out_ready  in  1  sink accepts head
out_rec  out  2+AW+2*DW  head record {kind, pc, addr, data}
count  out  clog2(DEPTH+1)  occupied entries
drop_cnt  out  CNTW  saturating count of lost records
overflow  out  1  sticky; any record lost
stopped  out  1  capture frozen by halt

Behaviour:
- Reset: pointers 0, count 0, drop_cnt 0, overflow 0, stopped 0, out_valid 0. Buffer contents are not reset.
- Lane i is accepted when ret_valid[i] & kind_mask[ret_kind_i] & enable & ~stopped. Kind 3 is never accepted, regardless of the mask.
- Accepted lanes are compacted in ascending lane order into consecutive slots from the write pointer. All writes land in a single cycle, and pointers wrap modulo DEPTH.
- Drain: out_valid = (count != 0). out_rec = entry at the read pointer (combinational from the array). A pop occurs when out_valid & out_ready.
- Free slots this cycle: free = DEPTH - count + pop.
- Stop-on-full (wrap_mode=0):
  - The first min(n_acc, free) accepted lanes, in lane order, are written.
  - The rest are dropped: drop_cnt += dropped (saturating at all-ones), and overflow is set.
- Wrap (wrap_mode=1):
  - All accepted lanes are written. excess = max(0, n_acc - free).
  - The read pointer advances by pop + excess, so the oldest entries are overwritten.
  - drop_cnt += excess; overflow is set if excess > 0. count saturates at DEPTH.
- Next count = count + written - pop - excess. Latency: a record captured in cycle t is visible on out_rec in cycle t+1 at the earliest.
- halt:
  - Records retiring in the cycle where halt=1 are still captured.
  - stopped is set at the next edge and holds until reset or restart.
  - If restart and halt are asserted together, halt wins.
  - Draining continues while stopped.
- Changing wrap_mode or kind_mask takes effect in the same cycle and does not disturb stored entries.
- A reset asserted mid-operation discards all entries at that edge. Records retired in the reset cycle are not captured.

Decomposition:
- Package trace_pkg holds:
  - kind encodings KIND_REG, KIND_MEM, KIND_PC
  - record typedef trace_rec_t {kind, pc, addr, data}
  - localparam REC_W
- Sub-module retire_lane_compact is natural. It is purely combinational and, per lane, produces accept, a prefix-sum slot offset and n_acc.
- The top level holds the pointers, count, array, drop and halt logic.

Test Plan:
- LANES=2, DEPTH=8, mask=4'b0111, lanes 0/1 retire REG pc=0x0010 r3=0x1234 and MEM pc=0x0011 m[0x0040]=0xBEEF in one cycle, out_ready=1 -> next cycle out_rec={REG,0010,0003,1234}, then {MEM,0011,0040,BEEF}; count 2 -> 1 -> 0.
- out_ready=0, wrap_mode=0, 5 cycles x 2 lanes valid -> count=8, drop_cnt=2, overflow=1; drained order is the first 8 records, lane 0 before lane 1.
- Same stimulus with wrap_mode=1 -> count=8, drop_cnt=2; first drained record is the 3rd captured.
- count=8, stop mode, pop plus 2 lanes valid in the same cycle -> 1 written, 1 dropped; count stays 8; drop_cnt +1.
- kind_mask=4'b0100, lanes carry REG and PC(target 0x0200) -> only PC captured, count=1, drop_cnt unchanged.
- halt=1 in the same cycle as a PC retire -> PC captured, stopped=1 next cycle, later retires ignored; restart -> capture resumes; reset mid-fill -> count=0, out_valid=0, drop_cnt=0.
